// File: rtl/vedic_mult_pipe.sv
// Pipelined W x W Vedic multiplier with a signed/unsigned mode per transaction
// and a sideband tag.
// S1: operand magnitudes and result sign.
// S2: four W/2 x W/2 partial products.
// S3: carry-save recombination, then sign restore.
// The three stages advance together and hold together, so backpressure
// freezes the whole pipe.
module vedic_mult_pipe #(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_sgn,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H = W / 2;

  // Magnitude of a possibly-signed operand; -2^(W-1) maps to 2^(W-1) unsigned.
  function automatic logic [W-1:0] to_mag(input logic [W-1:0] x, input logic sgn);
    logic signed [W-1:0] sx;
    sx = x;
    return (sgn && x[W-1]) ? W'(-sx) : x;
  endfunction

  // Restore the sign of the full product; -0 stays 0 naturally.
  function automatic logic [2*W-1:0] apply_sign(input logic [2*W-1:0] p, input logic neg);
    logic signed [2*W-1:0] sp;
    sp = p;
    return neg ? (2*W)'(-sp) : p;
  endfunction

  // 3:2 compressor, sum rail.
  function automatic logic [2*W-1:0] csa_sum(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                             input logic [2*W-1:0] c);
    return a ^ b ^ c;
  endfunction

  // 3:2 compressor, carry rail (already weighted by 2).
  function automatic logic [2*W-1:0] csa_carry(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                               input logic [2*W-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic                 w_adv;
  logic                 r_vld_p1, r_vld_p2, r_vld_p3;
  logic [W-1:0]         r_ma_p1, r_mb_p1;
  logic                 r_neg_p1, r_neg_p2;
  logic [TAG_W-1:0]     r_tag_p1, r_tag_p2, r_tag_p3;
  logic [W-1:0]         r_ll_p2, r_hh_p2, r_lh_p2, r_hl_p2;
  logic [2*W-1:0]       r_p_p3;
  logic [2*W-1:0]       w_opa, w_opb, w_opc, w_sum, w_cry, w_prod;

  assign w_adv     = ~r_vld_p3 | out_ready;
  assign in_ready  = ~rst & w_adv;
  assign out_valid = r_vld_p3;
  assign out_p     = r_p_p3;
  assign out_tag   = r_tag_p3;

  // Valid bits of all three stages shift together; reset drops in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= in_valid;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // ---- stage 1: operand magnitudes, result sign, tag ----
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_ma_p1  <= to_mag(in_a, in_sgn);
      r_mb_p1  <= to_mag(in_b, in_sgn);
      r_neg_p1 <= in_sgn & (in_a[W-1] ^ in_b[W-1]);
      r_tag_p1 <= in_tag;
    end
  end

  // ---- stage 2: four half-width partial products ----
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_ll_p2  <= {{H{1'b0}}, r_ma_p1[H-1:0]} * {{H{1'b0}}, r_mb_p1[H-1:0]};
      r_hh_p2  <= {{H{1'b0}}, r_ma_p1[W-1:H]} * {{H{1'b0}}, r_mb_p1[W-1:H]};
      r_lh_p2  <= {{H{1'b0}}, r_ma_p1[H-1:0]} * {{H{1'b0}}, r_mb_p1[W-1:H]};
      r_hl_p2  <= {{H{1'b0}}, r_ma_p1[W-1:H]} * {{H{1'b0}}, r_mb_p1[H-1:0]};
      r_neg_p2 <= r_neg_p1;
      r_tag_p2 <= r_tag_p1;
    end
  end

  // HH and LL do not overlap, so they share one operand; the two cross terms
  // are the other two. One 3:2 level leaves a single carry-propagate add.
  assign w_opa  = {r_hh_p2, r_ll_p2};
  assign w_opb  = {{H{1'b0}}, r_lh_p2, {H{1'b0}}};
  assign w_opc  = {{H{1'b0}}, r_hl_p2, {H{1'b0}}};
  assign w_sum  = csa_sum(w_opa, w_opb, w_opc);
  assign w_cry  = csa_carry(w_opa, w_opb, w_opc);
  assign w_prod = w_sum + w_cry;

  // ---- stage 3: signed product and tag; bubbles leave the output registers untouched ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_p3   <= '0;
      r_tag_p3 <= '0;
    end else if (w_adv && r_vld_p2) begin
      r_p_p3   <= apply_sign(w_prod, r_neg_p2);
      r_tag_p3 <= r_tag_p2;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench for vedic_mult_pipe (W=32): directed corner products,
// backpressure, bubbles, mid-flight reset and a randomized stream.
module tb_vedic_mult_pipe;

  localparam int W     = 32;
  localparam int TAG_W = 4;

  typedef struct {
    logic [2*W-1:0]   p;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic               in_sgn;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*W-1:0]     out_p;
  logic [TAG_W-1:0]   out_tag;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;
  bit   rnd_done = 1'b0;
  exp_t q[$];

  vedic_mult_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sgn(in_sgn), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: extend both operands to 2W bits by the selected rule and multiply.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Expected results are queued when the handshake is seen.
  always @(negedge clk) begin
    if (rst) q.delete();
    else if (in_valid && in_ready)
      q.push_back('{p: ref_mul(in_a, in_b, in_sgn), tag: in_tag, cyc: cyc, lat: lat_chk});
  end

  // Every output transfer is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("sb_p", out_p, e.p);
        chk("sb_tag", out_tag, e.tag);
        if (e.lat) chk("sb_latency", cyc - e.cyc, 3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TAG_W-1:0] t);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sgn = s; in_tag = t;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic check_now(input string nm, input logic [2*W-1:0] p, input logic [TAG_W-1:0] t);
    chk({nm, "_vld"}, out_valid, 1'b1);
    chk(nm, out_p, p);
    chk({nm, "_tag"}, out_tag, t);
  endtask

  task automatic wait_out(input string nm, input logic [2*W-1:0] p, input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_now(nm, p, t);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom % 6)
      0:       v = '0;
      1:       v = W'(1);
      2:       v = '1;
      3:       v = {1'b1, {(W-1){1'b0}}};
      4:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  logic [2*W-1:0]   held_p;
  logic [TAG_W-1:0] held_t;
  bit               pat[6];
  bit               ov[9];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sgn = 1'b0; in_tag = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_p", out_p, '0);
    chk("rst_out_tag", out_tag, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Unsigned max x max
    lat_chk = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h5);
    wait_out("umax", 64'hFFFF_FFFE_0000_0001, 4'h5);
    @(posedge clk); #1;

    // Signed corners, back to back, tags 1..4
    fork
      begin
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd1);
        send(32'd3,         32'hFFFF_FFFB, 1'b1, 4'd2);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd3);
        send(32'h8000_0000, 32'd1,         1'b1, 4'd4);
      end
      begin
        wait_out("s_m1m1", 64'h0000_0000_0000_0001, 4'd1);
        @(negedge clk); check_now("s_3m5",   64'hFFFF_FFFF_FFFF_FFF1, 4'd2);
        @(negedge clk); check_now("s_minmin", 64'h4000_0000_0000_0000, 4'd3);
        @(negedge clk); check_now("s_min1",  64'hFFFF_FFFF_8000_0000, 4'd4);
      end
    join
    lat_chk = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Backpressure: six random pairs, output stalled for five cycles
    fork
      begin
        for (int i = 0; i < 6; i++) send(W'($urandom), W'($urandom), 1'($urandom), TAG_W'(i));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        held_p = out_p;
        held_t = out_tag;
        for (int j = 0; j < 5; j++) begin
          if (j > 0) begin
            @(negedge clk);
            chk("stall_p_stable", out_p, held_p);
            chk("stall_tag_stable", out_tag, held_t);
          end
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk); #1;
    chk("bp_drained", q.size(), 0);

    // Bubbles: 1,0,1,0,0,1
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 6) ? pat[i] : 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_sgn = 1'($urandom); in_tag = TAG_W'(i);
      @(negedge clk);
      ov[i] = out_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) chk($sformatf("bubble_%0d", i), ov[i+3], pat[i]);
    repeat (4) @(posedge clk); #1;

    // Reset with work in flight: two accepted, a third offered during reset
    send(32'd11, 32'd12, 1'b0, 4'hA);
    send(32'd13, 32'd14, 1'b1, 4'hB);
    rst = 1'b1;
    in_valid = 1'b1; in_a = 32'd15; in_b = 32'd16; in_sgn = 1'b0; in_tag = 4'hC;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("after_rst_out_valid", out_valid, 1'b0);
      chk("after_rst_out_p", out_p, '0);
      chk("after_rst_out_tag", out_tag, '0);
    end
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(32'd7, 32'd9, 1'b0, 4'h3);
    wait_out("u7x9", 64'd63, 4'h3);
    lat_chk = 1'b0;
    @(posedge clk); #1;

    // Randomized stream with random gaps and random backpressure
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom % 4 == 0) begin
            @(posedge clk); #1;
          end
          send(rand_op(), rand_op(), 1'($urandom), TAG_W'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
        out_ready = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    chk("final_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
